// File: rtl/flag_cond_unit.sv
// ---------------------------------------------------------------------------
// flag_cond_unit
//
// Purpose:
//   Captures the ALU flags into a 4-bit status register {C,Z,N,V}. Evaluates
//   4-bit condition codes against that register for the control sequencer.
//   Each request is accepted over a valid/ready handshake and answered with a
//   registered result. A LIFO stack of DEPTH entries saves and restores
//   status words on subroutine/interrupt entry and exit.
//
// Configuration macro:
//   FLAG_BYPASS_EN - when defined, a condition accepted in the same cycle as
//                    a flag update (legal pop or flag_we) is evaluated
//                    against the updated flags. When undefined, it is
//                    evaluated against the registered flags_q, which leaves a
//                    one-cycle flag-to-branch hazard for the sequencer.
//
// Parameters:
//   DEPTH       - number of save-stack entries (>= 2)
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   flag_we     - capture {carry_in,zero_in,sign_in,ovf_in} at the next edge
//   carry_in, zero_in, sign_in, ovf_in - ALU flags
//   flags_q     - status register {C,Z,N,V}
//   cond_valid  - condition evaluation request
//   cond_code   - condition selector
//   cond_ready  - request accepted when cond_valid & cond_ready
//   take_valid  - result valid
//   take        - condition result (1 = branch taken)
//   take_ready  - sequencer consumes the result
//   push / pop  - save / restore flags_q on the stack
//   stack_empty - no saved entries
//   stack_full  - DEPTH entries saved
//   stack_err   - one-cycle pulse after an illegal stack operation
// ---------------------------------------------------------------------------
module flag_cond_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_we,
    input  logic       carry_in,
    input  logic       zero_in,
    input  logic       sign_in,
    input  logic       ovf_in,
    output logic [3:0] flags_q,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       take_valid,
    output logic       take,
    input  logic       take_ready,
    input  logic       push,
    input  logic       pop,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    // The stack pointer counts 0..DEPTH inclusive.
    // The entry index only ever addresses 0..DEPTH-1.
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]     r_flags;
    logic [SPW-1:0] r_sp;
    logic           r_take_valid;
    logic           r_take;
    logic           r_stack_err;
    logic [3:0]     r_stack [0:DEPTH-1];

    logic           w_empty;
    logic           w_full;
    logic           w_push_ok;
    logic           w_pop_ok;
    logic           w_illegal;
    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_rd_idx;
    logic [3:0]     w_flags_next;
    logic [3:0]     w_eval_flags;
    logic           w_accept;
    logic           w_result;

    // Condition table. The flags word is {C,Z,N,V}.
    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic c, z, n, v;
        c = f[3];
        z = f[2];
        n = f[1];
        v = f[0];
        case (code)
            4'h0:    eval_cond = z;
            4'h1:    eval_cond = !z;
            4'h2:    eval_cond = c;
            4'h3:    eval_cond = !c;
            4'h4:    eval_cond = n;
            4'h5:    eval_cond = !n;
            4'h6:    eval_cond = v;
            4'h7:    eval_cond = !v;
            4'h8:    eval_cond = c & !z;
            4'h9:    eval_cond = !c | z;
            4'hA:    eval_cond = (n == v);
            4'hB:    eval_cond = (n != v);
            4'hC:    eval_cond = !z & (n == v);
            4'hD:    eval_cond = z | (n != v);
            4'hE:    eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == SPW'(DEPTH));

    // push & pop in the same cycle is illegal as a pair.
    // Neither half of the pair takes effect.
    assign w_push_ok = push & !pop & !w_full;
    assign w_pop_ok  = pop & !push & !w_empty;
    assign w_illegal = (push & pop) | (push & w_full) | (pop & w_empty);

    assign w_wr_idx = IW'(r_sp);
    assign w_rd_idx = IW'(r_sp - 1'b1);

    // A legal pop has priority over flag_we.
    // The stack is read combinationally so that the restored value lands in
    // flags_q at the same edge that the pointer moves.
    always_comb begin
        w_flags_next = r_flags;
        if (w_pop_ok) begin
            w_flags_next = r_stack[w_rd_idx];
        end else if (flag_we) begin
            w_flags_next = {carry_in, zero_in, sign_in, ovf_in};
        end
    end

`ifdef FLAG_BYPASS_EN
    assign w_eval_flags = w_flags_next;
`else
    assign w_eval_flags = r_flags;
`endif

    // The output buffer holds one entry.
    // A new request is accepted when the buffer is empty or is being drained
    // this cycle.
    assign cond_ready = !r_take_valid | take_ready;
    assign w_accept   = cond_valid & cond_ready;
    assign w_result   = eval_cond(cond_code, w_eval_flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags      <= 4'b0000;
            r_sp         <= '0;
            r_take_valid <= 1'b0;
            r_take       <= 1'b0;
            r_stack_err  <= 1'b0;
        end else begin
            r_flags     <= w_flags_next;
            r_stack_err <= w_illegal;
            if (w_push_ok) begin
                r_sp <= r_sp + 1'b1;
            end else if (w_pop_ok) begin
                r_sp <= r_sp - 1'b1;
            end
            if (w_accept) begin
                r_take_valid <= 1'b1;
                r_take       <= w_result;
            end else if (take_ready) begin
                r_take_valid <= 1'b0;
            end
        end
    end

    // The stack storage has no reset. After a reset, sp = 0 makes every
    // entry unreachable until it is rewritten.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_stack[w_wr_idx] <= r_flags;
        end
    end

    assign flags_q     = r_flags;
    assign take_valid  = r_take_valid;
    assign take        = r_take;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_err   = r_stack_err;

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flag_we = 1'b0;
    logic       carry_in = 1'b0;
    logic       zero_in = 1'b0;
    logic       sign_in = 1'b0;
    logic       ovf_in = 1'b0;
    logic [3:0] flags_q;
    logic       cond_valid = 1'b0;
    logic [3:0] cond_code = 4'h0;
    logic       cond_ready;
    logic       take_valid;
    logic       take;
    logic       take_ready = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    flag_cond_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .carry_in(carry_in), .zero_in(zero_in), .sign_in(sign_in), .ovf_in(ovf_in),
        .flags_q(flags_q), .cond_valid(cond_valid), .cond_code(cond_code),
        .cond_ready(cond_ready), .take_valid(take_valid), .take(take),
        .take_ready(take_ready), .push(push), .pop(pop),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       take;
        logic [3:0] code;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         txn = 0;

    // Reference model state (spec level: flags word, stack as a queue)
    logic [3:0] m_flags;
    logic [3:0] m_stk[$];
    logic       m_tv;
    logic       m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch rule from named flags N,Z,C,V
    function automatic logic cond_ref(input logic [3:0] code, input logic [3:0] f);
        logic C, Z, N, V;
        {C, Z, N, V} = f;
        case (code)
            4'h0: return Z;
            4'h1: return !Z;
            4'h2: return C;
            4'h3: return !C;
            4'h4: return N;
            4'h5: return !N;
            4'h6: return V;
            4'h7: return !V;
            4'h8: return C && !Z;
            4'h9: return !C || Z;
            4'hA: return N == V;
            4'hB: return N != V;
            4'hC: return !Z && (N == V);
            4'hD: return Z || (N != V);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_stk.delete();
        m_tv = 1'b0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle.
    // Compares the registered outputs with the model, drives the inputs,
    // then advances the model.
    task automatic cycle(input logic fwe, input logic [3:0] fin, input logic cv,
                         input logic [3:0] cc, input logic tr,
                         input logic pu, input logic po);
        logic       rdy, ill, push_ok, pop_ok;
        logic [3:0] nf, ef;
        @(negedge clk);
        #1;
        chk("flags_q", 32'(flags_q), 32'(m_flags));
        chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
        chk("stack_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
        chk("stack_err", 32'(stack_err), 32'(m_err));
        chk("take_valid", 32'(take_valid), 32'(m_tv));
        flag_we = fwe;
        {carry_in, zero_in, sign_in, ovf_in} = fin;
        cond_valid = cv;
        cond_code = cc;
        take_ready = tr;
        push = pu;
        pop = po;
        #1;
        rdy = !m_tv || tr;
        chk("cond_ready", 32'(cond_ready), 32'(rdy));
        ill = (pu && po) || (pu && m_stk.size() == DEPTH) || (po && m_stk.size() == 0);
        push_ok = pu && !ill;
        pop_ok = po && !ill;
        nf = pop_ok ? m_stk[$] : (fwe ? fin : m_flags);
`ifdef FLAG_BYPASS_EN
        ef = nf;
`else
        ef = m_flags;
`endif
        if (cv && rdy) begin
            exp_q.push_back('{take: cond_ref(cc, ef), code: cc});
            m_tv = 1'b1;
        end else if (tr) begin
            m_tv = 1'b0;
        end
        if (push_ok) m_stk.push_back(m_flags);
        if (pop_ok) void'(m_stk.pop_back());
        m_flags = nf;
        m_err = ill;
    endtask

    task automatic idle(input logic tr);
        cycle(1'b0, 4'b0000, 1'b0, 4'h0, tr, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted and released away from the clock edges
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        flag_we = 1'b0; cond_valid = 1'b0; take_ready = 1'b0;
        push = 1'b0; pop = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: consumes one expected result per DUT handshake
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && take_valid && take_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: got take=%0b expected no result", take);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    txn++;
                    if (take !== e.take) begin
                        failures++;
                        $display("FAIL take code=%0h: got %0b expected %0b", e.code, take, e.take);
                    end else begin
                        $display("txn %0d code=%0h take=%0b", txn, e.code, take);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        #2;
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
        chk("reset take", 32'(take), 32'(0));

        // AL then NV after reset
        cycle(1'b0, 4'b0000, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // C=1 Z=0 N=1 V=0, then HI, GE, LT
        cycle(1'b1, 4'b1010, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Backpressure: the result is held while take_ready is low
        cycle(1'b0, 4'b0000, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b1, 4'(i + 8), 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Fill the stack, overflow once, drain it, underflow once
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'b1000 >> i, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        end
        cycle(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // push&pop together is illegal; pop&flag_we together lets the pop win
        cycle(1'b1, 4'b0110, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 4'b1111, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // Flag-to-branch hazard: Z set and EQ accepted in the same cycle
        cycle(1'b1, 4'b0100, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Reset while a result is pending
        cycle(1'b0, 4'b0000, 1'b1, 4'hE, 1'b0, 1'b1, 1'b0);
        do_reset();
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 9) < 7,
                  4'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        // Drain all outstanding results
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("results outstanding", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
